// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared debounce state encoding and default debounce length
package lock_pkg;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button synchroniser, debounce FSM and press event (BUTTON_CONDITIONER_DEBOUNCE_EN)
module btn_debounce
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    logic [1:0] sync_q;
    logic       sync;

    // two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign sync = sync_q[1];

`ifdef BUTTON_CONDITIONER_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    // debounce state and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // next state; counter restarts on every state entry and saturates at CNT_LAST
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press      = 1'b0;
        case (state)
            RELEASED: begin
                if (sync) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press      = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    assign level = (state == PRESSED) || (state == RELEASE_WAIT);
`else
    logic             sync_d;
    logic             press_q;
    logic [CNT_W-1:0] unused_cfg;

    // rising-edge detect on the synchronised level, registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_d  <= sync;
            press_q <= sync & ~sync_d;
        end
    end

    assign level      = sync;
    assign press      = press_q;
    assign unused_cfg = CNT_W'(DEBOUNCE_CYCLES);
`endif

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-button conditioner with one-pulse-per-cycle arbiter (BUTTON_CONDITIONER_DEBOUNCE_EN)
module button_conditioner
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset_in,
    input  logic b0_raw_in,
    input  logic b1_raw_in,
    output logic b0_out,
    output logic b1_out,
    output logic b0_level_out,
    output logic b1_level_out
);

    logic ev0, ev1;
    logic pend0, pend1;
    logic pend0_next, pend1_next;
    logic fire0, fire1;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_b0 (
        .clk   (clk),
        .rst_n (reset_in),
        .raw   (b0_raw_in),
        .level (b0_level_out),
        .press (ev0)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_b1 (
        .clk   (clk),
        .rst_n (reset_in),
        .raw   (b1_raw_in),
        .level (b1_level_out),
        .press (ev1)
    );

    // pending presses are served first, then new b0, then new b1; losers wait a cycle
    always_comb begin
        fire0      = 1'b0;
        fire1      = 1'b0;
        pend0_next = 1'b0;
        pend1_next = 1'b0;
        if (pend1) begin
            fire1      = 1'b1;
            pend0_next = pend0 | ev0;
            pend1_next = ev1;
        end else if (pend0) begin
            fire0      = 1'b1;
            pend0_next = ev0;
            pend1_next = ev1;
        end else if (ev0) begin
            fire0      = 1'b1;
            pend1_next = ev1;
        end else begin
            fire1 = ev1;
        end
    end

    // registered pulse outputs and pending flags
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            b0_out <= 1'b0;
            b1_out <= 1'b0;
            pend0  <= 1'b0;
            pend1  <= 1'b0;
        end else begin
            b0_out <= fire0;
            b1_out <= fire1;
            pend0  <= pend0_next;
            pend1  <= pend1_next;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - self-checking bench for button_conditioner (BUTTON_CONDITIONER_DEBOUNCE_EN aware)
module tb_button_conditioner;

    localparam int D = 4;
`ifdef BUTTON_CONDITIONER_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int LAT     = DB_EN ? D + 2 : 3;
    localparam int LAT_REL = DB_EN ? D + 2 : 1;

    logic clk = 1'b0;
    logic reset_in = 1'b1;
    logic b0_raw_in = 1'b0;
    logic b1_raw_in = 1'b0;
    logic b0_out, b1_out, b0_level_out, b1_level_out;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3)
    ) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .b0_raw_in    (b0_raw_in),
        .b1_raw_in    (b1_raw_in),
        .b0_out       (b0_out),
        .b1_out       (b1_out),
        .b0_level_out (b0_level_out),
        .b1_level_out (b1_level_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulses0, pulses1, last0, last1, first_low0;

    // reference model: sync pipeline, accepted levels, stability runs, press queue
    logic [1:0] m_s1, m_s2, m_d1, m_d2, m_lvl, m_out;
    int         m_run [2];
    int         m_q [$];

    typedef struct {
        logic r0, r1, o0, o1, l0, l1;
    } vec_t;
    vec_t tbl [18];

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0b, expected %0b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_d1 = '0; m_d2 = '0; m_lvl = '0; m_out = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input logic r0, input logic r1);
        logic [1:0] raw, ev;
        raw = {r1, r0};
        ev  = '0;
        for (int b = 0; b < 2; b++) begin
            if (DB_EN) begin
                // a new level is accepted after D+1 consecutive differing samples
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D + 1) begin
                        m_lvl[b] = m_s2[b];
                        m_run[b] = 0;
                        ev[b]    = m_s2[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
            end else begin
                ev[b]   = m_d1[b] & ~m_d2[b];
                m_d2[b] = m_d1[b];
                m_d1[b] = m_s2[b];
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
            if (!DB_EN) m_lvl[b] = m_s2[b];
        end
        if (ev[0]) m_q.push_back(0);
        if (ev[1]) m_q.push_back(1);
        m_out = '0;
        if (m_q.size() != 0) begin
            int w;
            w = m_q.pop_front();
            m_out[w] = 1'b1;
        end
    endtask

    task automatic clr_stats();
        pulses0 = 0; pulses1 = 0; last0 = -1; last1 = -1; first_low0 = -1;
    endtask

    task automatic step(input logic r0, input logic r1);
        b0_raw_in = r0;
        b1_raw_in = r1;
        @(posedge clk);
        if (reset_in) model_edge(r0, r1);
        cyc++;
        @(negedge clk);
        check("b0_out", b0_out, m_out[0]);
        check("b1_out", b1_out, m_out[1]);
        check("b0_level_out", b0_level_out, m_lvl[0]);
        check("b1_level_out", b1_level_out, m_lvl[1]);
        check("exclusive_pulse", b0_out & b1_out, 1'b0);
        if (b0_out) begin pulses0++; last0 = cyc; end
        if (b1_out) begin pulses1++; last1 = cyc; end
        if (!b0_level_out && first_low0 < 0) first_low0 = cyc;
    endtask

    task automatic seg(input logic r0, input logic r1, input int n);
        for (int i = 0; i < n; i++) step(r0, r1);
    endtask

    initial begin
        int base;
        int h0, h1;
        logic v0, v1;

        // simultaneous press then release of both buttons, cycle by cycle
        for (int i = 0; i < 18; i++) begin
            tbl[i].r0 = (i < 10); tbl[i].r1 = (i < 10);
            tbl[i].o0 = 1'b0; tbl[i].o1 = 1'b0;
            tbl[i].l0 = 1'b0; tbl[i].l1 = 1'b0;
        end
        for (int i = 0; i < 18; i++) begin
            if (i >= LAT && i < 10 + LAT_REL) begin
                tbl[i].l0 = 1'b1; tbl[i].l1 = 1'b1;
            end
        end
        if (!DB_EN) begin
            for (int i = 1; i < 11; i++) begin
                tbl[i].l0 = 1'b1; tbl[i].l1 = 1'b1;
            end
        end
        tbl[LAT].o0     = 1'b1;
        tbl[LAT + 1].o1 = 1'b1;

        model_reset();
        clr_stats();
        #1 reset_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_b0_out", b0_out, 1'b0);
        check("reset_b1_out", b1_out, 1'b0);
        check("reset_b0_level", b0_level_out, 1'b0);
        check("reset_b1_level", b1_level_out, 1'b0);
        reset_in = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r0, tbl[i].r1);
            check("tbl_b0_out", b0_out, tbl[i].o0);
            check("tbl_b1_out", b1_out, tbl[i].o1);
            check("tbl_b0_level", b0_level_out, tbl[i].l0);
            check("tbl_b1_level", b1_level_out, tbl[i].l1);
        end
        seg(0, 0, 4);

        // bounce on b1: 1,1,0,0,1,1,0,0 then held
        clr_stats();
        base = cyc;
        seg(0, 1, 2); seg(0, 0, 2); seg(0, 1, 2); seg(0, 0, 2);
        seg(0, 1, 12);
        check_int("bounce_pulse_count", pulses1, DB_EN ? 1 : 3);
        check_int("bounce_pulse_cycle", last1, base + 9 + LAT);
        seg(0, 0, 12);

        // b0 held, short drop, long drop, new press
        clr_stats();
        base = cyc;
        seg(1, 0, 10);
        check_int("held_pulse_count", pulses0, 1);
        check_int("held_pulse_cycle", last0, base + 1 + LAT);
        clr_stats();
        seg(0, 0, 3);
        seg(1, 0, 8);
        check_int("short_drop_pulses", pulses0, DB_EN ? 0 : 1);
        clr_stats();
        base = cyc;
        seg(0, 0, 10);
        check_int("release_level_fall", first_low0, base + 1 + LAT_REL);
        check_int("release_no_pulse", pulses0, 0);
        clr_stats();
        seg(1, 0, 10);
        check_int("repress_pulses", pulses0, 1);

        // asynchronous reset while pressed, button still held afterwards
        #2 reset_in = 1'b0;
        #1;
        check("async_reset_b0_level", b0_level_out, 1'b0);
        check("async_reset_b0_out", b0_out, 1'b0);
        check("async_reset_b1_out", b1_out, 1'b0);
        check("async_reset_b1_level", b1_level_out, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_in = 1'b1;
        clr_stats();
        base = cyc;
        seg(1, 0, 10);
        check_int("post_reset_pulses", pulses0, 1);
        check_int("post_reset_cycle", last0, base + 1 + LAT);
        seg(0, 0, 12);

        // randomized hold lengths on both buttons
        h0 = 0; h1 = 0; v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (h0 == 0) begin v0 = logic'($urandom_range(0, 1)); h0 = $urandom_range(1, 12); end
            if (h1 == 0) begin v1 = logic'($urandom_range(0, 1)); h1 = $urandom_range(1, 12); end
            step(v0, v1);
            h0--; h1--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
